bht_flush_ctrl: RTL and testbench
=================================

// Module: bht_flush_ctrl
// PURPOSE
//  Sequences a domain-partition flush of the bimodal BHT (counters+targets) on a context switch.
//  Sits between the fetch frontend / branch-resolve backend and the BHT: passes lookups and updates through
//  when idle; on flush request it drains in-flight updates, stalls fetch, sweeps every BHT entry of the
//  selected domain partition via the BHT clear port (one index per cycle), then acknowledges.
// PARAMETERS
//  IDX_WIDTH    `BHT_IDX_WIDTH  BHT index width; sweep covers 2**IDX_WIDTH entries
//  QUIESCE_CYC  2               cycles in DRAIN for the BHT's deferred (prev_idx) update to land; 0 allowed
// PORTS
//  clk_i             in   1          clock, all state on posedge
//  rst_ni            in   1          asynchronous reset, active-low
//  flush_req_i       in   1          level flush request (requester holds until ack)
//  flush_domain_i    in   domain_t   partition to flush: PRIV, USER, INIT = both
//  flush_ack_o       out  1          one-cycle pulse: flush complete
//  flush_busy_o      out  1          high from acceptance through ack cycle
//  fe_idx_i          in   IDX_WIDTH  frontend lookup index
//  fe_domain_i       in   domain_t   frontend lookup domain
//  fe_targ_i         in   32         frontend target for BHT target capture
//  fe_stall_o        out  1          frontend must hold its lookup
//  update_en_i       in   1          backend update enable
//  br_result_i       in   1          backend resolved direction
//  bht_idx_o         out  IDX_WIDTH  to BHT idx_i
//  bht_domain_o      out  domain_t   to BHT domain_i
//  bht_targ_o        out  32         to BHT targ_i
//  bht_update_en_o   out  1          to BHT update_en_i
//  bht_br_result_o   out  1          to BHT br_result_i
//  bht_clr_en_o      out  1          BHT clear strobe: entry -> 2'b00, target -> 0
//  bht_clr_idx_o     out  IDX_WIDTH  BHT entry being cleared
//  bht_clr_domain_o  out  domain_t   partition cleared; INIT = both partitions
// BEHAVIOUR
//  Reset (rst_ni low, async): state IDLE, sweep cnt 0, captured domain INIT; flush_ack_o=0, flush_busy_o=0,
//   fe_stall_o=0, bht_clr_en_o=0, bht_clr_idx_o=0, bht_clr_domain_o=INIT. Partial sweep is abandoned, never resumed or acked.
//  FSM IDLE -> DRAIN -> SWEEP -> DONE -> IDLE.
//   IDLE: flush_req_i=1 at posedge -> capture flush_domain_i; next DRAIN (SWEEP if QUIESCE_CYC=0).
//   DRAIN: QUIESCE_CYC cycles (down-counter); fe_stall_o=1; updates still pass to BHT; then SWEEP.
//   SWEEP: bht_clr_en_o=1, bht_clr_idx_o=cnt, bht_clr_domain_o=captured; cnt 0..2**IDX_WIDTH-1, +1/cycle;
//    after last index (all ones) -> DONE. Counter IDX_WIDTH+1 bits, no wrap. fe_stall_o=1, bht_update_en_o forced 0.
//   DONE: flush_ack_o=1 exactly one cycle, fe_stall_o=0, busy=1; next IDLE.
//  flush_busy_o=1 in DRAIN/SWEEP/DONE. Latency acceptance->ack = QUIESCE_CYC + 2**IDX_WIDTH + 1 cycles.
//  Passthrough (IDLE, DONE, DRAIN): bht_idx_o/domain_o/targ_o = fe_*; bht_update_en_o=update_en_i,
//   bht_br_result_o=br_result_i; combinational, zero latency. In SWEEP bht_idx_o/domain_o/targ_o still = fe_*.
//  Clear/stall/ack/busy outputs decode registered state/cnt only; no combinational path from flush_req_i.
//  flush_req_i and flush_domain_i are ignored outside IDLE (domain change mid-flush has no effect).
//  Req still high in the cycle after ack (IDLE) -> a second flush is accepted: back-to-back allowed; requester drops req after ack.
//  update_en_i during SWEEP is dropped (entry will be cleared anyway); the backend does not replay it.
// TESTING (IDX_WIDTH=4, QUIESCE_CYC=2, req accepted at cycle T)
//  Reset: rst_ni low mid-cycle during SWEEP idx 7 -> clr_en/stall/busy 0 immediately; after release IDLE, no ack.
//  USER flush: req@T -> stall T+1..T+18; clr_en T+3..T+18 idx 0..15 domain USER; ack only @T+19; busy T+1..T+19.
//  Update gating: update_en_i=1 @T+2 -> bht_update_en_o=1; update_en_i=1 @T+5 -> bht_update_en_o=0.
//  INIT flush: flush_domain_i=INIT -> bht_clr_domain_o=INIT on all 16 sweep cycles; change domain to PRIV @T+4 -> still INIT.
//  Back-to-back: req held through T+20 -> ack @T+19, second DRAIN @T+21, second ack @T+39.
//  QUIESCE_CYC=0 build: req@T -> clr_en idx 0 @T+1, idx 15 @T+16, ack @T+17.

Source files
------------

// File: rtl/bht_flush_ctrl.sv
`default_nettype none

// ============================================================================
//  Module   : bht_flush_ctrl (with companion package bht_flush_pkg)
//  Purpose  : Sequences a domain-partition flush of the bimodal BHT (direction
//             counters + captured targets) on a context switch.
//             When idle, lookups and updates pass straight through to the BHT.
//             When a flush is requested, the controller:
//               1. DRAIN : stalls fetch for QUIESCE_CYC cycles so the BHT's
//                          deferred (prev_idx) update can land.
//               2. SWEEP : strobes the BHT clear port once per index,
//                          0 .. 2**IDX_WIDTH-1, on the captured partition.
//               3. DONE  : pulses flush_ack_o for one cycle.
//  Ports    :
//    clk_i, rst_ni          clock / asynchronous active-low reset
//    flush_req_i            level flush request, held until ack
//    flush_domain_i         partition to flush (PRIV, USER, INIT = both)
//    flush_ack_o            one-cycle completion pulse
//    flush_busy_o           high from acceptance through the ack cycle
//    fe_idx_i/domain/targ   frontend lookup, forwarded to the BHT
//    fe_stall_o             frontend must hold its lookup
//    update_en_i            backend update enable
//    br_result_i            backend resolved direction
//    bht_idx_o/domain/targ  BHT lookup/update address, domain and target
//    bht_update_en_o        BHT update strobe (suppressed during SWEEP)
//    bht_br_result_o        BHT resolved direction
//    bht_clr_en_o           BHT clear strobe (entry -> 2'b00, target -> 0)
//    bht_clr_idx_o          index being cleared
//    bht_clr_domain_o       partition being cleared (INIT = both)
//  Revision : 1.0  initial release
// ============================================================================

`ifndef BHT_IDX_WIDTH
`define BHT_IDX_WIDTH 4
`endif

package bht_flush_pkg;

  // Domain tag shared with the BHT. INIT selects both partitions.
  typedef logic [1:0] domain_t;

  localparam domain_t c_dom_init = 2'b00;
  localparam domain_t c_dom_priv = 2'b01;
  localparam domain_t c_dom_user = 2'b10;

endpackage

module bht_flush_ctrl
  import bht_flush_pkg::*;
#(
  parameter int IDX_WIDTH   = `BHT_IDX_WIDTH,
  parameter int QUIESCE_CYC = 2
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,

  // Flush handshake
  input  logic                 flush_req_i,
  input  domain_t              flush_domain_i,
  output logic                 flush_ack_o,
  output logic                 flush_busy_o,

  // Frontend lookup
  input  logic [IDX_WIDTH-1:0] fe_idx_i,
  input  domain_t              fe_domain_i,
  input  logic [31:0]          fe_targ_i,
  output logic                 fe_stall_o,

  // Backend resolve
  input  logic                 update_en_i,
  input  logic                 br_result_i,

  // BHT lookup / update port
  output logic [IDX_WIDTH-1:0] bht_idx_o,
  output domain_t              bht_domain_o,
  output logic [31:0]          bht_targ_o,
  output logic                 bht_update_en_o,
  output logic                 bht_br_result_o,

  // BHT clear port
  output logic                 bht_clr_en_o,
  output logic [IDX_WIDTH-1:0] bht_clr_idx_o,
  output domain_t              bht_clr_domain_o
);

  // --------------------------------------------------------------------------
  // Constants
  // --------------------------------------------------------------------------

  // The drain down-counter must hold the value QUIESCE_CYC; keep at least one
  // bit so the QUIESCE_CYC=0 build still elaborates cleanly.
  localparam int c_qw = (QUIESCE_CYC > 0) ? $clog2(QUIESCE_CYC + 1) : 1;

  // Final sweep index. The sweep counter carries one extra bit so the
  // "last index" test never aliases with a wrapped-around zero.
  localparam logic [IDX_WIDTH:0] c_last_idx = {1'b0, {IDX_WIDTH{1'b1}}};

  localparam logic [c_qw-1:0] c_qload = c_qw'(QUIESCE_CYC);
  localparam logic [c_qw-1:0] c_qone  = c_qw'(1);

  // --------------------------------------------------------------------------
  // State
  // --------------------------------------------------------------------------
  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_DRAIN = 2'd1,
    S_SWEEP = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t             r_state;
  state_t             w_state_nxt;

  logic [IDX_WIDTH:0] r_cnt;      // sweep index, IDX_WIDTH+1 bits
  logic [c_qw-1:0]    r_qcnt;     // drain cycles remaining
  domain_t            r_dom;      // partition captured at acceptance

  logic               w_accept;
  logic               w_drain_last;
  logic               w_sweep_last;
  logic               w_in_sweep;

  // DRAIN is entered with r_qcnt = QUIESCE_CYC, so the cycle that observes 1
  // is the last drain cycle. Never evaluated when QUIESCE_CYC is 0 because
  // DRAIN is skipped entirely in that build.
  assign w_drain_last = (r_qcnt == c_qone);
  assign w_sweep_last = (r_cnt == c_last_idx);

  // --------------------------------------------------------------------------
  // FSM state register
  // --------------------------------------------------------------------------
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // --------------------------------------------------------------------------
  // FSM next-state and output decode
  //
  // Every flush-control output decodes registered state only, so there is no
  // combinational path from flush_req_i to stall/clear/ack/busy. The lookup
  // and update channel is a pure wire path in every state; only the update
  // strobe is masked while the sweep is clearing entries.
  // --------------------------------------------------------------------------
  always_comb begin
    w_state_nxt      = r_state;
    w_accept         = 1'b0;
    w_in_sweep       = 1'b0;

    flush_ack_o      = 1'b0;
    flush_busy_o     = 1'b0;
    fe_stall_o       = 1'b0;
    bht_clr_en_o     = 1'b0;
    bht_clr_idx_o    = r_cnt[IDX_WIDTH-1:0];
    bht_clr_domain_o = r_dom;

    bht_idx_o        = fe_idx_i;
    bht_domain_o     = fe_domain_i;
    bht_targ_o       = fe_targ_i;
    bht_br_result_o  = br_result_i;
    bht_update_en_o  = update_en_i;

    case (r_state)
      S_IDLE: begin
        if (flush_req_i) begin
          w_accept    = 1'b1;
          w_state_nxt = (QUIESCE_CYC == 0) ? S_SWEEP : S_DRAIN;
        end
      end

      S_DRAIN: begin
        // In-flight updates are still allowed through so the BHT's deferred
        // write completes before the sweep starts.
        flush_busy_o = 1'b1;
        fe_stall_o   = 1'b1;
        if (w_drain_last) begin
          w_state_nxt = S_SWEEP;
        end
      end

      S_SWEEP: begin
        flush_busy_o = 1'b1;
        fe_stall_o   = 1'b1;
        bht_clr_en_o = 1'b1;
        w_in_sweep   = 1'b1;
        if (w_sweep_last) begin
          w_state_nxt = S_DONE;
        end
      end

      S_DONE: begin
        // Request is ignored here; a still-high request is taken on the
        // following IDLE cycle, giving back-to-back flushes.
        flush_busy_o = 1'b1;
        flush_ack_o  = 1'b1;
        w_state_nxt  = S_IDLE;
      end

      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase

    // An update landing mid-sweep would target an entry that is being (or
    // will be) cleared; the backend does not replay it, so it is dropped.
    if (w_in_sweep) begin
      bht_update_en_o = 1'b0;
    end
  end

  // --------------------------------------------------------------------------
  // Captured flush domain
  // Sampled only on acceptance, so domain changes mid-flush have no effect.
  // --------------------------------------------------------------------------
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_dom <= c_dom_init;
    end else if (w_accept) begin
      r_dom <= flush_domain_i;
    end
  end

  // --------------------------------------------------------------------------
  // Drain down-counter
  // Loaded on acceptance, decremented through DRAIN.
  // --------------------------------------------------------------------------
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_qcnt <= '0;
    end else if (w_accept) begin
      r_qcnt <= c_qload;
    end else if ((r_state == S_DRAIN) && !w_drain_last) begin
      r_qcnt <= r_qcnt - c_qone;
    end
  end

  // --------------------------------------------------------------------------
  // Sweep counter
  // Counts 0..2**IDX_WIDTH-1 through SWEEP and is held at zero otherwise, so
  // each sweep starts from index 0. A reset mid-sweep abandons the partial
  // sweep; the next request starts a fresh one.
  // --------------------------------------------------------------------------
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_cnt <= '0;
    end else if (r_state == S_SWEEP) begin
      r_cnt <= r_cnt + 1'b1;
    end else begin
      r_cnt <= '0;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_bht_flush_ctrl.sv
`default_nettype none

// ============================================================================
//  Module   : tb_bht_flush_ctrl
//  Purpose  : Self-checking bench for bht_flush_ctrl. Two instances share the
//             stimulus: one with QUIESCE_CYC=2, one with QUIESCE_CYC=0.
//             A timeline model (acceptance cycle + offset) gives the expected
//             outputs every cycle; literal checks pin the key cycles.
//  Revision : 1.0  initial release
// ============================================================================

module tb_bht_flush_ctrl;
  import bht_flush_pkg::*;

  localparam int IW = 4;
  localparam int NE = 1 << IW;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  logic          flush_req = 1'b0;
  domain_t       flush_domain = c_dom_init;
  logic [IW-1:0] fe_idx = '0;
  domain_t       fe_domain = c_dom_init;
  logic [31:0]   fe_targ = '0;
  logic          update_en = 1'b0;
  logic          br_result = 1'b0;

  logic          o_ack    [2];
  logic          o_busy   [2];
  logic          o_stall  [2];
  logic          o_upd    [2];
  logic          o_br     [2];
  logic          o_clr_en [2];
  logic [IW-1:0] o_idx    [2];
  logic [IW-1:0] o_clr_idx[2];
  domain_t       o_dom    [2];
  domain_t       o_clr_dom[2];
  logic [31:0]   o_targ   [2];

  bht_flush_ctrl #(.IDX_WIDTH(IW), .QUIESCE_CYC(2)) u_dut_q2 (
    .clk_i(clk), .rst_ni(rst_n),
    .flush_req_i(flush_req), .flush_domain_i(flush_domain),
    .flush_ack_o(o_ack[0]), .flush_busy_o(o_busy[0]),
    .fe_idx_i(fe_idx), .fe_domain_i(fe_domain), .fe_targ_i(fe_targ),
    .fe_stall_o(o_stall[0]),
    .update_en_i(update_en), .br_result_i(br_result),
    .bht_idx_o(o_idx[0]), .bht_domain_o(o_dom[0]), .bht_targ_o(o_targ[0]),
    .bht_update_en_o(o_upd[0]), .bht_br_result_o(o_br[0]),
    .bht_clr_en_o(o_clr_en[0]), .bht_clr_idx_o(o_clr_idx[0]),
    .bht_clr_domain_o(o_clr_dom[0])
  );

  bht_flush_ctrl #(.IDX_WIDTH(IW), .QUIESCE_CYC(0)) u_dut_q0 (
    .clk_i(clk), .rst_ni(rst_n),
    .flush_req_i(flush_req), .flush_domain_i(flush_domain),
    .flush_ack_o(o_ack[1]), .flush_busy_o(o_busy[1]),
    .fe_idx_i(fe_idx), .fe_domain_i(fe_domain), .fe_targ_i(fe_targ),
    .fe_stall_o(o_stall[1]),
    .update_en_i(update_en), .br_result_i(br_result),
    .bht_idx_o(o_idx[1]), .bht_domain_o(o_dom[1]), .bht_targ_o(o_targ[1]),
    .bht_update_en_o(o_upd[1]), .bht_br_result_o(o_br[1]),
    .bht_clr_en_o(o_clr_en[1]), .bht_clr_idx_o(o_clr_idx[1]),
    .bht_clr_domain_o(o_clr_dom[1])
  );

  int n_vec = 0;
  int n_err = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s @%0t: got %0h expected %0h", nm, $time, act, exp);
    end
  endtask

  // --------------------------------------------------------------------------
  // Timeline model. A flush accepted in cycle A (request seen at the posedge
  // ending cycle A) occupies offsets 1..Q+NE+1 after A:
  //   stall 1..Q+NE, clear Q+1..Q+NE (index = off-Q-1), ack at Q+NE+1.
  // --------------------------------------------------------------------------
  int      cyc = 0;
  int      acc[2] = '{-1, -1};
  domain_t mdom[2];

  function automatic int qof(input int k);
    return (k == 0) ? 2 : 0;
  endfunction

  function automatic bit m_idle(input int k, input int c);
    return (acc[k] < 0) || ((c - acc[k]) >= qof(k) + NE + 2);
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc[0] = -1;
      acc[1] = -1;
    end else begin
      for (int k = 0; k < 2; k++) begin
        if (m_idle(k, cyc) && flush_req) begin
          acc[k]  = cyc;
          mdom[k] = flush_domain;
        end
      end
      cyc++;
    end
  end

  always @(negedge clk) begin : p_cmp
    int off;
    int q;
    bit e_busy, e_stall, e_clr, e_ack;
    for (int k = 0; k < 2; k++) begin
      q       = qof(k);
      off     = (acc[k] < 0) ? -1 : (cyc - acc[k]);
      e_busy  = (off >= 1) && (off <= q + NE + 1);
      e_stall = (off >= 1) && (off <= q + NE);
      e_clr   = (off >= q + 1) && (off <= q + NE);
      e_ack   = (off == q + NE + 1);
      chk($sformatf("busy[%0d]", k),   32'(o_busy[k]),   32'(e_busy));
      chk($sformatf("stall[%0d]", k),  32'(o_stall[k]),  32'(e_stall));
      chk($sformatf("clr_en[%0d]", k), 32'(o_clr_en[k]), 32'(e_clr));
      chk($sformatf("ack[%0d]", k),    32'(o_ack[k]),    32'(e_ack));
      if (e_clr) begin
        chk($sformatf("clr_idx[%0d]", k), 32'(o_clr_idx[k]), 32'(off - q - 1));
        chk($sformatf("clr_dom[%0d]", k), 32'(o_clr_dom[k]), 32'(mdom[k]));
      end
      chk($sformatf("upd[%0d]", k),  32'(o_upd[k]),  32'(update_en & ~e_clr));
      chk($sformatf("br[%0d]", k),   32'(o_br[k]),   32'(br_result));
      chk($sformatf("idx[%0d]", k),  32'(o_idx[k]),  32'(fe_idx));
      chk($sformatf("dom[%0d]", k),  32'(o_dom[k]),  32'(fe_domain));
      chk($sformatf("targ[%0d]", k), o_targ[k], fe_targ);
    end
  end

  // --------------------------------------------------------------------------
  // Stimulus: each step() moves to the next cycle and refreshes the
  // frontend/backend traffic; directed overrides follow the call.
  // --------------------------------------------------------------------------
  task automatic step();
    @(posedge clk);
    #1;
    fe_idx    = IW'($urandom_range(NE - 1, 0));
    fe_domain = domain_t'($urandom_range(3, 0));
    fe_targ   = $urandom;
    br_result = 1'($urandom_range(1, 0));
    update_en = 1'($urandom_range(1, 0));
  endtask

  int ack_cnt;

  initial begin
    // Reset state
    #1 rst_n = 1'b0;
    #1;
    for (int k = 0; k < 2; k++) begin
      chk("rst_ack",     32'(o_ack[k]),     32'd0);
      chk("rst_busy",    32'(o_busy[k]),    32'd0);
      chk("rst_stall",   32'(o_stall[k]),   32'd0);
      chk("rst_clr_en",  32'(o_clr_en[k]),  32'd0);
      chk("rst_clr_idx", 32'(o_clr_idx[k]), 32'd0);
      chk("rst_clr_dom", 32'(o_clr_dom[k]), 32'(c_dom_init));
    end
    repeat (3) step();
    rst_n = 1'b1;
    repeat (5) step();

    // USER flush, single
    step();
    flush_req = 1'b1; flush_domain = c_dom_user;
    for (int k = 1; k <= 22; k++) begin
      step();
      if (k == 2 || k == 5) update_en = 1'b1;
      if (k == 20) flush_req = 1'b0;
      @(negedge clk);
      #1;
      case (k)
        1:  begin chk("u_stall_T1", 32'(o_stall[0]), 32'd1); chk("u_busy_T1", 32'(o_busy[0]), 32'd1);
                  chk("q0_clr_T1", 32'(o_clr_en[1]), 32'd1); chk("q0_idx_T1", 32'(o_clr_idx[1]), 32'd0); end
        2:  begin chk("u_upd_drain", 32'(o_upd[0]), 32'd1); chk("u_clr_T2", 32'(o_clr_en[0]), 32'd0); end
        3:  begin chk("u_clr_T3", 32'(o_clr_en[0]), 32'd1); chk("u_idx_T3", 32'(o_clr_idx[0]), 32'd0);
                  chk("u_dom_T3", 32'(o_clr_dom[0]), 32'(c_dom_user)); end
        5:  chk("u_upd_sweep", 32'(o_upd[0]), 32'd0);
        16: chk("q0_idx_T16", 32'(o_clr_idx[1]), 32'd15);
        17: chk("q0_ack_T17", 32'(o_ack[1]), 32'd1);
        18: begin chk("u_idx_T18", 32'(o_clr_idx[0]), 32'd15); chk("u_ack_T18", 32'(o_ack[0]), 32'd0); end
        19: begin chk("u_ack_T19", 32'(o_ack[0]), 32'd1); chk("u_stall_T19", 32'(o_stall[0]), 32'd0);
                  chk("u_busy_T19", 32'(o_busy[0]), 32'd1); end
        20: chk("u_busy_T20", 32'(o_busy[0]), 32'd0);
        default: ;
      endcase
    end
    repeat (25) step();

    // INIT flush, domain input changed mid-flush
    step();
    flush_req = 1'b1; flush_domain = c_dom_init;
    for (int k = 1; k <= 22; k++) begin
      step();
      if (k == 4) flush_domain = c_dom_priv;
      if (k == 20) flush_req = 1'b0;
      @(negedge clk);
      #1;
      if (k == 3)  chk("i_dom_T3",  32'(o_clr_dom[0]), 32'(c_dom_init));
      if (k == 10) chk("i_dom_T10", 32'(o_clr_dom[0]), 32'(c_dom_init));
    end
    repeat (25) step();

    // Back-to-back flushes: request held through T+20
    step();
    flush_req = 1'b1; flush_domain = c_dom_priv;
    for (int k = 1; k <= 45; k++) begin
      step();
      if (k == 21) flush_req = 1'b0;
      @(negedge clk);
      #1;
      case (k)
        19: chk("b_ack_T19", 32'(o_ack[0]), 32'd1);
        20: begin chk("b_busy_T20", 32'(o_busy[0]), 32'd0); chk("b_ack_T20", 32'(o_ack[0]), 32'd0); end
        21: begin chk("b_stall_T21", 32'(o_stall[0]), 32'd1); chk("b_busy_T21", 32'(o_busy[0]), 32'd1); end
        38: chk("b_ack_T38", 32'(o_ack[0]), 32'd0);
        39: chk("b_ack_T39", 32'(o_ack[0]), 32'd1);
        default: ;
      endcase
    end
    repeat (25) step();

    // Asynchronous reset in the middle of the sweep (index 7)
    step();
    flush_req = 1'b1; flush_domain = c_dom_user;
    for (int k = 1; k <= 10; k++) step();
    chk("r_idx_before", 32'(o_clr_idx[0]), 32'd7);
    #2;
    rst_n = 1'b0;
    flush_req = 1'b0;
    #1;
    chk("r_clr_en", 32'(o_clr_en[0]), 32'd0);
    chk("r_stall",  32'(o_stall[0]),  32'd0);
    chk("r_busy",   32'(o_busy[0]),   32'd0);
    repeat (2) step();
    rst_n = 1'b1;
    ack_cnt = 0;
    for (int k = 0; k < 25; k++) begin
      step();
      @(negedge clk);
      #1;
      ack_cnt += int'(o_ack[0]) + int'(o_ack[1]);
    end
    chk("r_no_ack", 32'(ack_cnt), 32'd0);
    chk("r_idle_busy", 32'(o_busy[0]), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

`default_nettype wire
